// File: rtl/regfile_rename_if.sv
// Bus between decoder/ROB and the renaming register file.
// master: decoder + ROB side (drives commit, rename, source indices).
// slave : register file (returns operand status/value, commit count).
interface regfile_rename_if #(
  parameter int REG_ID_W = 5,
  parameter int ROB_ID_W = 4
);
  logic                rdy_in;
  logic                commit_en;
  logic [REG_ID_W-1:0] commit_reg;
  logic [ROB_ID_W-1:0] commit_rob_id;
  logic [31:0]         commit_value;
  logic                clear_all;
  logic                rename_en;
  logic [REG_ID_W-1:0] rename_reg;
  logic [ROB_ID_W-1:0] rename_rob_id;
  logic [REG_ID_W-1:0] rs1_id, rs2_id;
  logic                rs1_busy, rs2_busy;
  logic [ROB_ID_W-1:0] rs1_reorder, rs2_reorder;
  logic [31:0]         rs1_value, rs2_value;
  logic [31:0]         commit_count;

  modport master (
    output rdy_in, commit_en, commit_reg, commit_rob_id, commit_value,
           clear_all, rename_en, rename_reg, rename_rob_id, rs1_id, rs2_id,
    input  rs1_busy, rs2_busy, rs1_reorder, rs2_reorder,
           rs1_value, rs2_value, commit_count
  );
  modport slave (
    input  rdy_in, commit_en, commit_reg, commit_rob_id, commit_value,
           clear_all, rename_en, rename_reg, rename_rob_id, rs1_id, rs2_id,
    output rs1_busy, rs2_busy, rs1_reorder, rs2_reorder,
           rs1_value, rs2_value, commit_count
  );
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags.
// Ports:
//   clk_in  rising-edge clock
//   rst_in  asynchronous active-high reset
//   bus     regfile_rename_if.slave: commit (ROB), rename (decoder),
//           clear_all flush, two combinational source read ports with
//           commit bypass, and a running commit counter.

// One source read port: reports busy/tag/value for an index, forwarding
// a same-cycle commit whose tag still owns the register.
module regfile_rename_rd #(
  parameter int REG_NUM  = 32,
  parameter int REG_ID_W = 5,
  parameter int ROB_ID_W = 4
) (
  input  logic [REG_ID_W-1:0]              id_i,
  input  logic [REG_NUM-1:0]               busy_i,
  input  logic [REG_NUM-1:0][ROB_ID_W-1:0] tag_i,
  input  logic [REG_NUM-1:0][31:0]         value_i,
  input  logic                             cm_en_i,
  input  logic [REG_ID_W-1:0]              cm_reg_i,
  input  logic [ROB_ID_W-1:0]              cm_rob_i,
  input  logic [31:0]                      cm_val_i,
  output logic                             busy_o,
  output logic [ROB_ID_W-1:0]              reorder_o,
  output logic [31:0]                      value_o
);
  logic byp;
  assign byp = cm_en_i && (cm_reg_i == id_i) && busy_i[id_i] &&
               (tag_i[id_i] == cm_rob_i);

  always_comb begin
    busy_o    = busy_i[id_i];
    reorder_o = tag_i[id_i];
    value_o   = value_i[id_i];
    if (id_i == '0) begin
      busy_o    = 1'b0;
      reorder_o = '0;
      value_o   = '0;
    end else if (byp) begin
      busy_o  = 1'b0;
      value_o = cm_val_i;
    end
  end
endmodule

module regfile_rename #(
  parameter int REG_NUM  = 32,
  parameter int REG_ID_W = 5,
  parameter int ROB_ID_W = 4
) (
  input logic            clk_in,
  input logic            rst_in,
  regfile_rename_if.slave bus
);
  localparam int NPORT = 2;

  logic [REG_NUM-1:0][31:0]         value_q, value_d;
  logic [REG_NUM-1:0]               busy_q,  busy_d;
  logic [REG_NUM-1:0][ROB_ID_W-1:0] tag_q,   tag_d;
  logic [31:0]                      cnt_q,   cnt_d;

  // Statement order matters: flush beats rename, rename beats the
  // commit's tag-clear on the same register.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    if (bus.rdy_in) begin
      if (bus.commit_en) begin
        cnt_d = cnt_q + 32'd1;
        if (bus.commit_reg != '0) begin
          value_d[bus.commit_reg] = bus.commit_value;
          // A mismatched tag means a younger writer still owns the reg.
          if (busy_q[bus.commit_reg] && tag_q[bus.commit_reg] == bus.commit_rob_id)
            busy_d[bus.commit_reg] = 1'b0;
        end
      end
      if (bus.clear_all) begin
        busy_d = '0;
      end else if (bus.rename_en && bus.rename_reg != '0) begin
        busy_d[bus.rename_reg] = 1'b1;
        tag_d[bus.rename_reg]  = bus.rename_rob_id;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.commit_count = cnt_q;

  logic [NPORT-1:0][REG_ID_W-1:0] rd_id;
  logic [NPORT-1:0]               rd_busy;
  logic [NPORT-1:0][ROB_ID_W-1:0] rd_tag;
  logic [NPORT-1:0][31:0]         rd_val;

  assign rd_id[0] = bus.rs1_id;
  assign rd_id[1] = bus.rs2_id;

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    regfile_rename_rd #(
      .REG_NUM (REG_NUM),
      .REG_ID_W(REG_ID_W),
      .ROB_ID_W(ROB_ID_W)
    ) u_rd (
      .id_i     (rd_id[p]),
      .busy_i   (busy_q),
      .tag_i    (tag_q),
      .value_i  (value_q),
      .cm_en_i  (bus.commit_en && bus.rdy_in),
      .cm_reg_i (bus.commit_reg),
      .cm_rob_i (bus.commit_rob_id),
      .cm_val_i (bus.commit_value),
      .busy_o   (rd_busy[p]),
      .reorder_o(rd_tag[p]),
      .value_o  (rd_val[p])
    );
  end

  assign bus.rs1_busy    = rd_busy[0];
  assign bus.rs2_busy    = rd_busy[1];
  assign bus.rs1_reorder = rd_tag[0];
  assign bus.rs2_reorder = rd_tag[1];
  assign bus.rs1_value   = rd_val[0];
  assign bus.rs2_value   = rd_val[1];
endmodule

// File: tb/tb_regfile_rename.sv
module tb_regfile_rename;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   tests  = 0;
  int   fails  = 0;

  regfile_rename_if #(.REG_ID_W(5), .ROB_ID_W(4)) bus ();
  regfile_rename #(.REG_NUM(32), .REG_ID_W(5), .ROB_ID_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.commit_en = 0; bus.rename_en = 0; bus.clear_all = 0;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic ren(input logic [4:0] r, input logic [3:0] id);
    bus.rename_en = 1; bus.rename_reg = r; bus.rename_rob_id = id;
  endtask

  task automatic cmt(input logic [4:0] r, input logic [3:0] id, input logic [31:0] v);
    bus.commit_en = 1; bus.commit_reg = r; bus.commit_rob_id = id; bus.commit_value = v;
  endtask

  initial begin
    bus.rdy_in = 1; bus.rs1_id = 0; bus.rs2_id = 0;
    bus.commit_reg = 0; bus.commit_rob_id = 0; bus.commit_value = 0;
    bus.rename_reg = 0; bus.rename_rob_id = 0;
    idle();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 0;

    // reset state
    bus.rs1_id = 5; bus.rs2_id = 0; #1;
    chk("rst_rs1_busy", 32'(bus.rs1_busy), 0);
    chk("rst_rs1_val",  bus.rs1_value, 0);
    chk("rst_rs2_busy", 32'(bus.rs2_busy), 0);
    chk("rst_rs2_val",  bus.rs2_value, 0);
    chk("rst_cnt",      bus.commit_count, 0);

    // rename x5 -> rob 3, then commit with bypass
    ren(5, 3); #1;
    chk("ren_same_cycle_hidden", 32'(bus.rs1_busy), 0);
    tick(); idle(); #1;
    chk("x5_busy",    32'(bus.rs1_busy), 1);
    chk("x5_reorder", 32'(bus.rs1_reorder), 3);
    cmt(5, 3, 32'hDEADBEEF); #1;
    chk("x5_byp_busy", 32'(bus.rs1_busy), 0);
    chk("x5_byp_val",  bus.rs1_value, 32'hDEADBEEF);
    tick(); idle(); #1;
    chk("x5_st_busy", 32'(bus.rs1_busy), 0);
    chk("x5_st_val",  bus.rs1_value, 32'hDEADBEEF);
    chk("cnt1",       bus.commit_count, 1);

    // double rename of x7, older commit must not clear busy
    ren(7, 2); tick(); ren(7, 6); tick(); idle();
    bus.rs1_id = 7;
    cmt(7, 2, 32'h11); #1;
    chk("x7_nobyp_busy", 32'(bus.rs1_busy), 1);
    chk("x7_nobyp_val",  bus.rs1_value, 0);
    tick(); idle(); #1;
    chk("x7_old_val",  bus.rs1_value, 32'h11);
    chk("x7_old_busy", 32'(bus.rs1_busy), 1);
    chk("x7_old_tag",  32'(bus.rs1_reorder), 6);
    cmt(7, 6, 32'h22); #1;
    chk("x7_byp_val", bus.rs1_value, 32'h22);
    tick(); idle(); #1;
    chk("x7_busy", 32'(bus.rs1_busy), 0);
    chk("x7_val",  bus.rs1_value, 32'h22);
    chk("cnt3",    bus.commit_count, 3);

    // same-cycle rename + matching commit on x9: rename wins
    ren(9, 1); tick(); idle();
    bus.rs1_id = 9;
    ren(9, 4); cmt(9, 1, 32'h33); #1;
    chk("x9_byp_busy", 32'(bus.rs1_busy), 0);
    chk("x9_byp_val",  bus.rs1_value, 32'h33);
    tick(); idle(); #1;
    chk("x9_busy", 32'(bus.rs1_busy), 1);
    chk("x9_tag",  32'(bus.rs1_reorder), 4);
    chk("x9_val",  bus.rs1_value, 32'h33);

    // flush with concurrent rename (dropped) and commit (kept)
    ren(1, 0); tick(); ren(2, 1); tick(); ren(3, 2); tick(); idle();
    bus.rs1_id = 2; #1;
    chk("x2_busy_pre", 32'(bus.rs1_busy), 1);
    chk("x2_tag_pre",  32'(bus.rs1_reorder), 1);
    bus.clear_all = 1; ren(4, 3); cmt(1, 0, 32'h55);
    tick(); idle();
    bus.rs1_id = 1; bus.rs2_id = 2; #1;
    chk("fl_x1_busy", 32'(bus.rs1_busy), 0);
    chk("fl_x1_val",  bus.rs1_value, 32'h55);
    chk("fl_x2_busy", 32'(bus.rs2_busy), 0);
    chk("fl_x2_tag",  32'(bus.rs2_reorder), 1);
    bus.rs1_id = 3; bus.rs2_id = 4; #1;
    chk("fl_x3_busy", 32'(bus.rs1_busy), 0);
    chk("fl_x4_busy", 32'(bus.rs2_busy), 0);
    chk("fl_x4_tag",  32'(bus.rs2_reorder), 0);
    bus.rs1_id = 9; #1;
    chk("fl_x9_busy", 32'(bus.rs1_busy), 0);
    chk("cnt5",       bus.commit_count, 5);

    // x0 is hardwired
    bus.rs1_id = 0;
    cmt(0, 0, 32'h1234); ren(0, 5); #1;
    chk("x0_byp_val", bus.rs1_value, 0);
    tick(); idle(); #1;
    chk("x0_busy", 32'(bus.rs1_busy), 0);
    chk("x0_val",  bus.rs1_value, 0);
    chk("x0_tag",  32'(bus.rs1_reorder), 0);
    chk("cnt6",    bus.commit_count, 6);

    // rdy_in low holds everything
    bus.rdy_in = 0; bus.rs1_id = 3; bus.rs2_id = 5;
    cmt(3, 2, 32'h99); ren(5, 7);
    tick(); idle(); bus.rdy_in = 1; #1;
    chk("hold_x3_val",  bus.rs1_value, 0);
    chk("hold_x5_busy", 32'(bus.rs2_busy), 0);
    chk("hold_cnt",     bus.commit_count, 6);

    // async reset mid-cycle
    ren(6, 5); tick(); idle();
    bus.rs1_id = 6; #1;
    chk("x6_busy", 32'(bus.rs1_busy), 1);
    #2 rst_in = 1; #1;
    chk("arst_x6_busy", 32'(bus.rs1_busy), 0);
    chk("arst_x5_val",  bus.rs2_value, 0);
    chk("arst_cnt",     bus.commit_count, 0);
    tick(); rst_in = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
